// File: rtl/dsa_job_ctrl_if.sv
// Host register port and core control/config bundle for dsa_job_ctrl.
// slave: the controller side; master: the host + core side (bench or top level).
interface dsa_job_ctrl_if;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic [31:0] reg_rdata;
  logic        core_start;
  logic        core_busy;
  logic        core_done;
  logic [15:0] core_in_w;
  logic [15:0] core_in_h;
  logic [15:0] core_scale_q88;
  logic [15:0] core_out_w;
  logic [15:0] core_out_h;
  logic        core_srst;
  logic        irq;

  modport slave (
    input  reg_addr, reg_wdata, reg_we, core_busy, core_done, core_out_w, core_out_h,
    output reg_rdata, core_start, core_in_w, core_in_h, core_scale_q88, core_srst, irq
  );

  modport master (
    output reg_addr, reg_wdata, reg_we, core_busy, core_done, core_out_w, core_out_h,
    input  reg_rdata, core_start, core_in_w, core_in_h, core_scale_q88, core_srst, irq
  );
endinterface

// File: rtl/dsa_job_ctrl.sv
// Job controller for the bilinear scaling core: validated 2-entry job FIFO, launch FSM, stats.
// Define DSA_CTRL_TIMEOUT_EN to enable the RUN-state watchdog and the core_srst pulse.
module dsa_job_ctrl #(
  parameter int unsigned AW          = 12,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input logic           clk_50,
  input logic           rst_n,
  dsa_job_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StSrst} state_e;

  localparam logic [32:0] AreaMax = 33'd1 << AW;

  state_e      state_q, state_d;
  logic [15:0] in_w_q, in_h_q, scale_q;
  logic [47:0] fifo_mem_q [2];
  logic        fifo_wr_q, fifo_rd_q;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [47:0] cfg_q;
  logic [31:0] cyc_q, cyc_inc, cycles_q, result_q, rdata_q, rdata_d, area;
  logic [15:0] jobs_q;
  logic        done_q, err_cfg_q, err_ovf_q, err_to_q, srst_cnt_q;
  logic        ctrl_wr, push, clr, flush, cfg_bad, fifo_full, do_push, do_pop;
  logic        job_done, wdog_trip;
  logic        unused_ok;

  assign ctrl_wr   = bus.reg_we && (bus.reg_addr == 3'd0);
  assign push      = ctrl_wr && bus.reg_wdata[0];
  assign clr       = ctrl_wr && bus.reg_wdata[1];
  assign flush     = ctrl_wr && bus.reg_wdata[2];
  assign area      = {16'd0, in_w_q} * {16'd0, in_h_q};
  assign cfg_bad   = (in_w_q == 16'd0) || (in_h_q == 16'd0) || (scale_q == 16'd0) ||
                     ({1'b0, area} > AreaMax);
  assign fifo_full = (fifo_cnt_q == 2'd2);
  // Shadows are registers, so a PUSH always sees the pre-write values.
  assign do_push   = push && !cfg_bad && !fifo_full && !flush;
  assign do_pop    = (state_q == StIdle) && (fifo_cnt_q != 2'd0);
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + 32'd1;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    if (flush) fifo_cnt_d = 2'd0;
  end

  always_comb begin
    state_d   = state_q;
    job_done  = 1'b0;
    wdog_trip = 1'b0;
    case (state_q)
      StIdle:   if (fifo_cnt_q != 2'd0) state_d = StLaunch;
      StLaunch: state_d = StRun;
      StRun: begin
        if (bus.core_done) begin
          state_d  = StIdle;
          job_done = 1'b1;
        end
`ifdef DSA_CTRL_TIMEOUT_EN
        else if (cyc_q >= TIMEOUT_CYC) begin
          state_d   = StSrst;
          wdog_trip = 1'b1;
        end
`endif
      end
      StSrst:   if (srst_cnt_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = 32'd0;
    case (bus.reg_addr)
      3'd1:    rdata_d = {16'd0, in_w_q};
      3'd2:    rdata_d = {16'd0, in_h_q};
      3'd3:    rdata_d = {16'd0, scale_q};
      3'd4:    rdata_d = {25'd0, fifo_cnt_q, err_to_q, err_ovf_q, err_cfg_q, done_q,
                          state_q != StIdle};
      3'd5:    rdata_d = result_q;
      3'd6:    rdata_d = cycles_q;
      3'd7:    rdata_d = {16'd0, jobs_q};
      default: rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      in_w_q        <= '0;
      in_h_q        <= '0;
      scale_q       <= '0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_cnt_q    <= '0;
      cfg_q         <= '0;
      cyc_q         <= '0;
      cycles_q      <= '0;
      result_q      <= '0;
      jobs_q        <= '0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_to_q      <= 1'b0;
      srst_cnt_q    <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q    <= state_d;
      fifo_cnt_q <= fifo_cnt_d;
      rdata_q    <= rdata_d;
      if (bus.reg_we) begin
        case (bus.reg_addr)
          3'd1:    in_w_q  <= bus.reg_wdata[15:0];
          3'd2:    in_h_q  <= bus.reg_wdata[15:0];
          3'd3:    scale_q <= bus.reg_wdata[15:0];
          default: ;
        endcase
      end
      if (do_push) begin
        fifo_mem_q[fifo_wr_q] <= {scale_q, in_h_q, in_w_q};
        fifo_wr_q             <= ~fifo_wr_q;
      end
      if (flush)       fifo_rd_q <= fifo_wr_q;
      else if (do_pop) fifo_rd_q <= ~fifo_rd_q;
      if (do_pop) cfg_q <= fifo_mem_q[fifo_rd_q];
      // The launch cycle itself counts toward CYCLES.
      if (state_q == StLaunch)   cyc_q <= 32'd1;
      else if (state_q == StRun) cyc_q <= cyc_inc;
      if (job_done) begin
        result_q <= {bus.core_out_h, bus.core_out_w};
        cycles_q <= cyc_inc;
        jobs_q   <= jobs_q + 16'd1;
      end
      srst_cnt_q <= (state_q == StSrst) ? ~srst_cnt_q : 1'b0;
      // Set beats a same-cycle CLR.
      done_q    <= job_done || (done_q && !clr);
      err_cfg_q <= (push && cfg_bad) || (err_cfg_q && !clr);
      err_ovf_q <= (push && !cfg_bad && fifo_full) || (err_ovf_q && !clr);
      err_to_q  <= wdog_trip || (err_to_q && !clr);
    end
  end

  assign bus.reg_rdata      = rdata_q;
  assign bus.core_start     = (state_q == StLaunch);
  assign bus.core_in_w      = cfg_q[15:0];
  assign bus.core_in_h      = cfg_q[31:16];
  assign bus.core_scale_q88 = cfg_q[47:32];
  assign bus.irq            = done_q || err_cfg_q || err_ovf_q || err_to_q;
`ifdef DSA_CTRL_TIMEOUT_EN
  assign bus.core_srst      = (state_q == StSrst);
`else
  assign bus.core_srst      = 1'b0;
`endif

  assign unused_ok = ^{bus.reg_wdata[31:16], bus.core_busy, TIMEOUT_CYC};

endmodule

// File: tb/tb_dsa_job_ctrl.sv
// Directed self-checking bench for dsa_job_ctrl with a simple latency-programmable core model.
module tb_dsa_job_ctrl;
  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  always #10 clk_50 = ~clk_50;

  dsa_job_ctrl_if bus ();

  dsa_job_ctrl #(
    .AW          (12),
    .TIMEOUT_CYC (32'd50)
  ) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // Core model: done pulse model_lat cycles after the start cycle; model_lat==0 never finishes.
  int          model_lat  = 10;
  logic [15:0] model_ow   = 16'd51;
  logic [15:0] model_oh   = 16'd51;
  int          m_cnt      = 0;
  bit          m_run      = 1'b0;
  int          start_cnt  = 0;
  int          done_cnt   = 0;
  int          last_start = -1;
  int          last_done  = -1;

  always @(negedge clk_50) begin
    if (!rst_n) begin
      m_run          = 1'b0;
      bus.core_done  = 1'b0;
      bus.core_busy  = 1'b0;
      bus.core_out_w = 16'd0;
      bus.core_out_h = 16'd0;
    end else begin
      bus.core_done = 1'b0;
      if (m_run && m_cnt != 0) begin
        if (m_cnt == 1) begin
          bus.core_done  = 1'b1;
          bus.core_out_w = model_ow;
          bus.core_out_h = model_oh;
          bus.core_busy  = 1'b0;
          m_run          = 1'b0;
          done_cnt++;
          last_done = cyc;
        end else begin
          m_cnt--;
        end
      end
      if (bus.core_start) begin
        m_run         = 1'b1;
        m_cnt         = model_lat;
        bus.core_busy = 1'b1;
        start_cnt++;
        last_start = cyc;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_we    = 1'b1;
    @(posedge clk_50);
    #1;
    bus.reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    @(posedge clk_50);
    #1;
    d = bus.reg_rdata;
  endtask

  task automatic wait_start(input int s0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && start_cnt <= s0; i++) step(1);
    if (start_cnt > s0) ok = 1'b1;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && done_cnt <= d0; i++) step(1);
    if (done_cnt > d0) ok = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    bus.reg_addr  = 3'd0;
    bus.reg_wdata = 32'd0;
    bus.reg_we    = 1'b0;
    rst_n         = 1'b0;
    step(3);
    n_cmp++;
    if ({bus.core_start, bus.core_srst, bus.irq} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000", {bus.core_start, bus.core_srst, bus.irq});
    end
    n_cmp++;
    if ({bus.core_in_w, bus.core_in_h, bus.core_scale_q88, bus.reg_rdata} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_cfg: got %h want 0",
               {bus.core_in_w, bus.core_in_h, bus.core_scale_q88, bus.reg_rdata});
    end
    rst_n = 1'b1;
    step(1);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", v); end
    rd(3'd7, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_jobs: got %h want 0", v); end
  endtask

  task automatic test_single_job();
    logic [31:0] v;
    int t, s0, d0;
    bit cfg_ok;
    model_lat = 20;
    wr(3'd1, 32'hABCD_0040);
    wr(3'd2, 32'd64);
    wr(3'd3, 32'd205);
    rd(3'd1, v);
    n_cmp++;
    if (v !== 32'd64) begin n_fail++; $display("FAIL in_w_upper_ignored: got %h want 40", v); end
    s0 = start_cnt;
    d0 = done_cnt;
    t  = cyc;
    wr(3'd0, 32'd1);
    cfg_ok = 1'b1;
    for (int i = 0; i < 200 && done_cnt <= d0; i++) begin
      if (start_cnt > s0 && {bus.core_in_w, bus.core_in_h, bus.core_scale_q88} !==
          {16'd64, 16'd64, 16'd205}) cfg_ok = 1'b0;
      step(1);
    end
    n_cmp++;
    if (start_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL single_starts: got %0d want 1", start_cnt - s0);
    end
    n_cmp++;
    if (last_start !== t + 2) begin
      n_fail++;
      $display("FAIL single_latency: got cycle %0d want %0d", last_start, t + 2);
    end
    n_cmp++;
    if (!cfg_ok) begin n_fail++; $display("FAIL single_cfg_stable: got unstable want 64/64/205"); end
    n_cmp++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b want 1", bus.irq); end
    rd(3'd5, v);
    n_cmp++;
    if (v !== 32'h0033_0033) begin n_fail++; $display("FAIL single_result: got %h want 00330033", v); end
    rd(3'd7, v);
    n_cmp++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL single_jobs: got %h want 1", v); end
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL single_status: got %h want 2", v); end
  endtask

  task automatic test_validation();
    logic [31:0] v;
    int s0;
    s0 = start_cnt;
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd1);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h6) begin n_fail++; $display("FAIL val_zero_w: got %h want 6", v); end
    wr(3'd1, 32'd65);
    wr(3'd0, 32'd2);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL val_clr: got %h want 0", v); end
    wr(3'd0, 32'd1);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL val_area: got %h want 4", v); end
    wr(3'd0, 32'd3);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL val_set_beats_clr: got %h want 4", v); end
    step(5);
    n_cmp++;
    if (start_cnt !== s0) begin
      n_fail++;
      $display("FAIL val_no_start: got %0d starts want %0d", start_cnt, s0);
    end
    wr(3'd0, 32'd2);
    rd(3'd4, v);
    n_cmp++;
    if ({v, bus.irq} !== 33'd0) begin n_fail++; $display("FAIL val_clr_all: got %h want 0", {v, bus.irq}); end
  endtask

  task automatic test_queue();
    logic [31:0] v;
    int s0, d0, da;
    bit ok;
    wr(3'd1, 32'd64);
    model_lat = 60;
    s0 = start_cnt;
    d0 = done_cnt;
    wr(3'd0, 32'd1);
    wait_start(s0, 10, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL q_first_start: got none want start"); end
    model_lat = 10;
    repeat (3) wr(3'd0, 32'd1);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h49) begin n_fail++; $display("FAIL q_full_ovf: got %h want 49", v); end
    for (int j = 0; j < 2; j++) begin
      wait_done(d0 + j, 100, ok);
      da = last_done;
      wait_start(s0 + 1 + j, 10, ok);
      n_cmp++;
      if (!ok || last_start !== da + 2) begin
        n_fail++;
        $display("FAIL q_back_to_back%0d: got cycle %0d want %0d", j, last_start, da + 2);
      end
    end
    wait_done(d0 + 2, 100, ok);
    rd(3'd7, v);
    n_cmp++;
    if (v !== 32'd4) begin n_fail++; $display("FAIL q_jobs: got %h want 4", v); end
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h0A) begin n_fail++; $display("FAIL q_status_end: got %h want 0a", v); end
  endtask

  task automatic test_cycles_flush();
    logic [31:0] v;
    int s0, d0, s1;
    bit ok;
    model_lat = 100;
    s0 = start_cnt;
    d0 = done_cnt;
    wr(3'd0, 32'd1);
    wait_start(s0, 10, ok);
    wr(3'd0, 32'd1);
    wr(3'd0, 32'd5);
    rd(3'd4, v);
    n_cmp++;
    if (v[6:5] !== 2'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", v[6:5]); end
    wait_done(d0, 150, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL cyc_done: got no done want done"); end
    rd(3'd6, v);
    n_cmp++;
    if (v !== 32'd101) begin n_fail++; $display("FAIL cycles: got %0d want 101", v); end
    s1 = start_cnt;
    step(6);
    n_cmp++;
    if (start_cnt !== s1) begin
      n_fail++;
      $display("FAIL flush_no_launch: got %0d starts want %0d", start_cnt, s1);
    end
  endtask

`ifdef DSA_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] v;
    int s0, n_srst;
    bit ok;
    model_lat = 0;
    s0 = start_cnt;
    wr(3'd0, 32'd2);
    wr(3'd0, 32'd1);
    wait_start(s0, 10, ok);
    n_srst = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (bus.core_srst === 1'b1) n_srst++;
    end
    n_cmp++;
    if (n_srst !== 2) begin n_fail++; $display("FAIL to_srst_len: got %0d want 2", n_srst); end
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h10) begin n_fail++; $display("FAIL to_status: got %h want 10", v); end
    rd(3'd7, v);
    n_cmp++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL to_jobs: got %h want 5", v); end
  endtask
`else
  task automatic test_no_timeout();
    logic [31:0] v;
    int s0;
    bit ok;
    model_lat = 0;
    s0 = start_cnt;
    wr(3'd0, 32'd1);
    wait_start(s0, 10, ok);
    step(10000);
    rd(3'd4, v);
    n_cmp++;
    if ({v[4], v[0], bus.core_srst} !== 3'b010) begin
      n_fail++;
      $display("FAIL no_to_still_run: got %b want 010", {v[4], v[0], bus.core_srst});
    end
  endtask
`endif

  task automatic test_mid_reset();
    logic [31:0] v;
    int s0;
    model_lat = 0;
    wr(3'd0, 32'd1);
    wr(3'd0, 32'd1);
    step(5);
    rd(3'd4, v);
    n_cmp++;
    if (v[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", v[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.core_start, bus.core_srst, bus.irq, bus.reg_rdata} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_rst_out: got %h want 0",
               {bus.core_start, bus.core_srst, bus.irq, bus.reg_rdata});
    end
    n_cmp++;
    if ({bus.core_in_w, bus.core_in_h, bus.core_scale_q88} !== 48'd0) begin
      n_fail++;
      $display("FAIL mid_rst_cfg: got %h want 0",
               {bus.core_in_w, bus.core_in_h, bus.core_scale_q88});
    end
    step(2);
    rst_n = 1'b1;
    s0 = start_cnt;
    step(4);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL mid_status: got %h want 0", v); end
    n_cmp++;
    if (start_cnt !== s0) begin
      n_fail++;
      $display("FAIL mid_fifo_empty: got %0d starts want %0d", start_cnt, s0);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_validation();
    test_queue();
    test_cycles_flush();
`ifdef DSA_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
